// File: rtl/logos_pkg.sv
// Shared widths, command entry layout and dispatcher state encoding for the
// logos command dispatcher.
package logos_pkg;

    localparam int OPCODE_W   = 8;
    localparam int SLOT_W     = 4;
    localparam int DMA_ADDR_W = 48;

    // Consecutive ready-high ACK cycles that mark a zero-latency completion.
    localparam int ACK_WINDOW = 2;

    typedef struct packed {
        logic                  target;
        logic [DMA_ADDR_W-1:0] dma_addr;
        logic [SLOT_W-1:0]     slot;
        logic [OPCODE_W-1:0]   opcode;
    } cmd_entry_t;

    localparam int CMD_ENTRY_W = $bits(cmd_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_DONE_WAIT
    } disp_state_t;

endpackage

// File: rtl/logos_cmd_fifo.sv
// Synchronous FIFO holding queued host commands; the head entry is readable
// combinationally so the dispatcher can load it on the issue edge.
module logos_cmd_fifo #(
    parameter int WIDTH = 61,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/logos_cmd_dispatcher.sv
// Host command queue and single-outstanding issuer for the NTT core command port.
// Optional watchdog in DONE_WAIT is enabled with LOGOS_DISPATCH_TIMEOUT_EN.
module logos_cmd_dispatcher
    import logos_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_valid,
    output logic                   host_ready,
    input  logic [7:0]             host_opcode,
    input  logic [3:0]             host_slot,
    input  logic [47:0]            host_dma_addr,
    input  logic                   host_target,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_opcode,
    output logic [3:0]             cmd_slot,
    output logic [47:0]            cmd_dma_addr,
    output logic                   cmd_target,
    input  logic                   core_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   done_pulse,
    output logic [15:0]            done_count,
    output logic                   err_timeout
);

    localparam int ACK_CNT_W = $clog2(ACK_WINDOW + 1);

    disp_state_t          state_reg;
    disp_state_t          state_next;
    logic [ACK_CNT_W-1:0] ack_cnt_reg;
    logic [ACK_CNT_W-1:0] ack_cnt_next;
    cmd_entry_t           cmd_entry_reg;
    cmd_entry_t           host_entry;
    cmd_entry_t           head_entry;
    logic                 cmd_valid_reg;
    logic                 done_pulse_reg;
    logic [15:0]          done_count_reg;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue;
    logic                 complete;
    logic                 issue_block;
    logic                 timeout_reached;

    assign host_entry = '{target:   host_target,
                          dma_addr: host_dma_addr,
                          slot:     host_slot,
                          opcode:   host_opcode};

    logos_cmd_fifo #(
        .WIDTH (CMD_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (host_valid && !fifo_full),
        .push_data (host_entry),
        .pop       (issue),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next   = state_reg;
        ack_cnt_next = ack_cnt_reg;
        issue        = 1'b0;
        complete     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && core_ready && !issue_block) begin
                    issue        = 1'b1;
                    ack_cnt_next = '0;
                    state_next   = ST_ACK;
                end
            end
            ST_ACK: begin
                // Ready that never drops inside the window means the core finished instantly.
                if (!core_ready) begin
                    state_next = ST_DONE_WAIT;
                end else if (ack_cnt_reg == ACK_CNT_W'(ACK_WINDOW - 1)) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    ack_cnt_next = ack_cnt_reg + ACK_CNT_W'(1);
                end
            end
            ST_DONE_WAIT: begin
                if (core_ready) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end else if (timeout_reached) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ack_cnt_reg    <= '0;
            cmd_entry_reg  <= '0;
            cmd_valid_reg  <= 1'b0;
            done_pulse_reg <= 1'b0;
            done_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ack_cnt_reg    <= ack_cnt_next;
            cmd_valid_reg  <= issue;
            done_pulse_reg <= complete;
            if (issue) begin
                cmd_entry_reg <= head_entry;
            end
            if (complete) begin
                done_count_reg <= done_count_reg + 16'd1;
            end
        end
    end

`ifdef LOGOS_DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            err_timeout_reg;

    assign timeout_reached = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign issue_block     = err_timeout_reg;
    assign err_timeout     = err_timeout_reg;

    // Counts only consecutive DONE_WAIT cycles with the core still busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg      <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (state_reg != ST_DONE_WAIT || core_ready || timeout_reached) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end
            if (state_reg == ST_DONE_WAIT && !core_ready && timeout_reached) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end
`else
    assign timeout_reached = 1'b0;
    assign issue_block     = 1'b0;
    assign err_timeout     = 1'b0;

    // Without the watchdog TIMEOUT_CYCLES has no effect.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    assign host_ready   = !fifo_full;
    assign busy         = (state_reg != ST_IDLE) || !fifo_empty;
    assign cmd_valid    = cmd_valid_reg;
    assign cmd_opcode   = cmd_entry_reg.opcode;
    assign cmd_slot     = cmd_entry_reg.slot;
    assign cmd_dma_addr = cmd_entry_reg.dma_addr;
    assign cmd_target   = cmd_entry_reg.target;
    assign done_pulse   = done_pulse_reg;
    assign done_count   = done_count_reg;

endmodule

// File: tb/tb_logos_cmd_dispatcher.sv
// Directed self-checking bench for logos_cmd_dispatcher (DEPTH=8).
// The watchdog scenario runs only when LOGOS_DISPATCH_TIMEOUT_EN is defined.
module tb_logos_cmd_dispatcher;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [81+CW:0] RESET_IMAGE = {1'b1, {(81+CW){1'b0}}};

    logic          clk = 1'b0;
    logic          rst;
    logic          host_valid;
    logic          host_ready;
    logic [7:0]    host_opcode;
    logic [3:0]    host_slot;
    logic [47:0]   host_dma_addr;
    logic          host_target;
    logic          cmd_valid;
    logic [7:0]    cmd_opcode;
    logic [3:0]    cmd_slot;
    logic [47:0]   cmd_dma_addr;
    logic          cmd_target;
    logic          core_ready;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          done_pulse;
    logic [15:0]   done_count;
    logic          err_timeout;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_seen    = 0;
    logic [60:0] issued_q[$];
    int          issued_cyc_q[$];

    always #5 clk = ~clk;

    logos_cmd_dispatcher #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_opcode   (host_opcode),
        .host_slot     (host_slot),
        .host_dma_addr (host_dma_addr),
        .host_target   (host_target),
        .cmd_valid     (cmd_valid),
        .cmd_opcode    (cmd_opcode),
        .cmd_slot      (cmd_slot),
        .cmd_dma_addr  (cmd_dma_addr),
        .cmd_target    (cmd_target),
        .core_ready    (core_ready),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .done_pulse    (done_pulse),
        .done_count    (done_count),
        .err_timeout   (err_timeout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every issued command and completion pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                issued_q.push_back({cmd_target, cmd_dma_addr, cmd_slot, cmd_opcode});
                issued_cyc_q.push_back(cyc);
                $display("[TB] issue  op=%02h slot=%0d addr=%012h tgt=%0b cyc=%0d",
                         cmd_opcode, cmd_slot, cmd_dma_addr, cmd_target, cyc);
            end
            if (done_pulse) begin
                done_seen++;
                $display("[TB] done   count=%0d cyc=%0d", done_count, cyc);
            end
        end
    end

    function automatic logic [60:0] mk(input logic [7:0] op, input logic [3:0] sl,
                                       input logic [47:0] ad, input logic tg);
        return {tg, ad, sl, op};
    endfunction

    function automatic logic [81+CW:0] out_image();
        return {host_ready, cmd_valid, cmd_opcode, cmd_slot, cmd_dma_addr, cmd_target,
                busy, fifo_count, done_pulse, done_count, err_timeout};
    endfunction

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cmd(input logic [60:0] e);
        host_valid = 1'b1;
        {host_target, host_dma_addr, host_slot, host_opcode} = e;
    endtask

    task automatic push_cmd(input logic [60:0] e);
        drive_cmd(e);
        cycle(1);
        host_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_seen < target && n < budget) begin
            cycle(1);
            n++;
        end
        tests_run++;
        if (done_seen != target) begin
            tests_failed++;
            $display("FAIL wait_done: got %0d completions, expected %0d", done_seen, target);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        host_valid = 1'b0;
        host_opcode = '0;
        host_slot = '0;
        host_dma_addr = '0;
        host_target = 1'b0;
        core_ready = 1'b1;
        cycle(2);
        tests_run++;
        if (out_image() !== RESET_IMAGE) begin
            tests_failed++;
            $display("FAIL reset_values: got %h expected %h", out_image(), RESET_IMAGE);
        end
        rst = 1'b0;
        cycle(1);
    endtask

    task automatic test_single;
        logic [60:0] e;
        e = mk(8'h02, 4'd3, 48'h1000, 1'b0);
        issued_q.delete();
        done_seen = 0;
        push_cmd(e);
        tests_run++;
        if (fifo_count !== CW'(1) || cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_after_push: count=%0d valid=%0b expected 1/0", fifo_count, cmd_valid);
        end
        cycle(1);
        tests_run++;
        if (cmd_valid !== 1'b1 || {cmd_target, cmd_dma_addr, cmd_slot, cmd_opcode} !== e) begin
            tests_failed++;
            $display("FAIL single_issue: valid=%0b fields=%h expected 1/%h", cmd_valid,
                     {cmd_target, cmd_dma_addr, cmd_slot, cmd_opcode}, e);
        end
        cycle(1);
        core_ready = 1'b0;
        tests_run++;
        if (cmd_valid !== 1'b0 || fifo_count !== CW'(0)) begin
            tests_failed++;
            $display("FAIL single_strobe_len: valid=%0b count=%0d expected 0/0", cmd_valid, fifo_count);
        end
        cycle(10);
        tests_run++;
        if (done_pulse !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_waiting: done=%0b busy=%0b expected 0/1", done_pulse, busy);
        end
        core_ready = 1'b1;
        cycle(1);
        tests_run++;
        if (done_pulse !== 1'b1 || done_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_done: pulse=%0b count=%0d expected 1/1", done_pulse, done_count);
        end
        cycle(1);
        tests_run++;
        if (done_pulse !== 1'b0 || busy !== 1'b0 || issued_q.size() != 1 || done_seen != 1) begin
            tests_failed++;
            $display("FAIL single_settle: pulse=%0b busy=%0b issues=%0d dones=%0d expected 0/0/1/1",
                     done_pulse, busy, issued_q.size(), done_seen);
        end
    endtask

    task automatic test_zero_latency;
        done_seen = 0;
        push_cmd(mk(8'h05, 4'd7, 48'h0000_0000_2222, 1'b1));
        cycle(1);
        tests_run++;
        if (cmd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL zl_issue: valid=%0b expected 1", cmd_valid);
        end
        cycle(1);
        tests_run++;
        if (done_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL zl_early_done: pulse=%0b expected 0", done_pulse);
        end
        cycle(1);
        tests_run++;
        if (done_pulse !== 1'b1 || done_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL zl_done: pulse=%0b count=%0d expected 1/2", done_pulse, done_count);
        end
        cycle(1);
        tests_run++;
        if (busy !== 1'b0 || done_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL zl_idle: busy=%0b pulse=%0b expected 0/0", busy, done_pulse);
        end
    endtask

    task automatic test_back_to_back;
        logic [60:0] exp_e[3];
        exp_e[0] = mk(8'hA0, 4'd1, 48'h0001_0000_0000, 1'b0);
        exp_e[1] = mk(8'hA1, 4'd2, 48'h0002_0000_0000, 1'b1);
        exp_e[2] = mk(8'hA2, 4'd4, 48'hFFFF_FFFF_FFFF, 1'b0);
        issued_q.delete();
        issued_cyc_q.delete();
        done_seen = 0;
        drive_cmd(exp_e[0]);
        cycle(1);
        drive_cmd(exp_e[1]);
        cycle(1);
        tests_run++;
        if (fifo_count !== CW'(1)) begin
            tests_failed++;
            $display("FAIL b2b_pushpop_count: got %0d expected 1", fifo_count);
        end
        drive_cmd(exp_e[2]);
        cycle(1);
        host_valid = 1'b0;
        wait_done(3, 40);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= issued_q.size() || issued_q[i] !== exp_e[i]) begin
                tests_failed++;
                $display("FAIL b2b_order[%0d]: got %h expected %h", i,
                         (i < issued_q.size()) ? issued_q[i] : 61'h0, exp_e[i]);
            end
        end
        tests_run++;
        if (issued_cyc_q.size() != 3 || issued_cyc_q[1] - issued_cyc_q[0] != 3 ||
            issued_cyc_q[2] - issued_cyc_q[1] != 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing: issues=%0d expected 3 issues 3 cycles apart", issued_cyc_q.size());
        end
        tests_run++;
        if (done_count !== 16'd5) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d expected 5", done_count);
        end
    endtask

    function automatic logic [60:0] fill_entry(input int i);
        return mk(8'h10 + 8'(i), 4'(i), 48'h2000 + 48'(i) * 48'h100, i[0]);
    endfunction

    task automatic test_fill;
        int n = 0;
        issued_q.delete();
        done_seen = 0;
        core_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push_cmd(fill_entry(i));
        end
        tests_run++;
        if (fifo_count !== CW'(DEPTH) || host_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_full: count=%0d ready=%0b busy=%0b expected 8/0/1",
                     fifo_count, host_ready, busy);
        end
        drive_cmd(fill_entry(DEPTH));
        cycle(2);
        tests_run++;
        if (fifo_count !== CW'(DEPTH) || cmd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_held_off: count=%0d valid=%0b expected 8/0", fifo_count, cmd_valid);
        end
        core_ready = 1'b1;
        while (!host_ready && n < 20) begin
            cycle(1);
            n++;
        end
        tests_run++;
        if (host_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_ready_return: ready=%0b expected 1", host_ready);
        end
        cycle(1);
        host_valid = 1'b0;
        wait_done(DEPTH + 1, 100);
        for (int i = 0; i <= DEPTH; i++) begin
            tests_run++;
            if (i >= issued_q.size() || issued_q[i] !== fill_entry(i)) begin
                tests_failed++;
                $display("FAIL fill_order[%0d]: got %h expected %h", i,
                         (i < issued_q.size()) ? issued_q[i] : 61'h0, fill_entry(i));
            end
        end
    endtask

    function automatic logic [60:0] pp_entry(input int i);
        return mk(8'h40 + 8'(i), 4'hF - 4'(i), 48'hABCD_0000 + 48'(i), ~i[0]);
    endfunction

    task automatic test_push_pop;
        issued_q.delete();
        done_seen = 0;
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(pp_entry(i));
        end
        tests_run++;
        if (fifo_count !== CW'(4)) begin
            tests_failed++;
            $display("FAIL pp_count4: got %0d expected 4", fifo_count);
        end
        drive_cmd(pp_entry(4));
        core_ready = 1'b1;
        cycle(1);
        host_valid = 1'b0;
        tests_run++;
        if (fifo_count !== CW'(4) || cmd_valid !== 1'b1 ||
            {cmd_target, cmd_dma_addr, cmd_slot, cmd_opcode} !== pp_entry(0)) begin
            tests_failed++;
            $display("FAIL pp_simul: count=%0d valid=%0b fields=%h expected 4/1/%h", fifo_count,
                     cmd_valid, {cmd_target, cmd_dma_addr, cmd_slot, cmd_opcode}, pp_entry(0));
        end
        wait_done(5, 60);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= issued_q.size() || issued_q[i] !== pp_entry(i)) begin
                tests_failed++;
                $display("FAIL pp_order[%0d]: got %h expected %h", i,
                         (i < issued_q.size()) ? issued_q[i] : 61'h0, pp_entry(i));
            end
        end
    endtask

    task automatic test_reset_mid;
        issued_q.delete();
        done_seen = 0;
        core_ready = 1'b1;
        push_cmd(mk(8'h70, 4'd0, 48'h7000, 1'b0));
        cycle(1);
        core_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            push_cmd(mk(8'h70 + 8'(i), 4'(i), 48'h7000 + 48'(i), 1'b1));
        end
        tests_run++;
        if (fifo_count !== CW'(3) || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL rm_queued: count=%0d busy=%0b expected 3/1", fifo_count, busy);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (out_image() !== RESET_IMAGE) begin
            tests_failed++;
            $display("FAIL rm_reset_values: got %h expected %h", out_image(), RESET_IMAGE);
        end
        cycle(1);
        rst = 1'b0;
        core_ready = 1'b1;
        cycle(10);
        tests_run++;
        if (issued_q.size() != 1 || done_seen != 0 || out_image() !== RESET_IMAGE) begin
            tests_failed++;
            $display("FAIL rm_after_reset: issues=%0d dones=%0d image=%h expected 1/0/%h",
                     issued_q.size(), done_seen, out_image(), RESET_IMAGE);
        end
    endtask

`ifdef LOGOS_DISPATCH_TIMEOUT_EN
    task automatic test_timeout;
        issued_q.delete();
        done_seen = 0;
        core_ready = 1'b1;
        push_cmd(mk(8'h99, 4'd9, 48'h9000, 1'b0));
        cycle(1);
        core_ready = 1'b0;
        cycle(16);
        tests_run++;
        if (err_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_early: err=%0b expected 0", err_timeout);
        end
        cycle(1);
        tests_run++;
        if (err_timeout !== 1'b1 || done_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_flag: err=%0b pulse=%0b expected 1/0", err_timeout, done_pulse);
        end
        core_ready = 1'b1;
        push_cmd(mk(8'h9A, 4'd10, 48'h9100, 1'b1));
        cycle(10);
        tests_run++;
        if (issued_q.size() != 1 || done_seen != 0 || fifo_count !== CW'(1) || err_timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL to_blocked: issues=%0d dones=%0d count=%0d err=%0b expected 1/0/1/1",
                     issued_q.size(), done_seen, fifo_count, err_timeout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero_latency();
        test_back_to_back();
        test_fill();
        test_push_pop();
        test_reset_mid();
`ifdef LOGOS_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
